line_clear: RTL and testbench

//  Runs after a falling piece is locked into the board RAM, once collision has reported collides_down.

---
 rtl/tetris_pkg.sv | 39 +++
 rtl/line_clear_addr_gen.sv | 15 +
 rtl/line_clear.sv | 196 +++++++++++++++++++
 tb/tb_line_clear.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, cell/address types, line_clear FSM states and score table.
package tetris_pkg;

  localparam int BOARD_COLS   = 10;
  localparam int BOARD_ROWS   = 24;
  localparam int CELL_W       = 6;
  localparam int BOARD_ADDR_W = 8;

  typedef logic [CELL_W-1:0]       cell_t;
  typedef logic [BOARD_ADDR_W-1:0] board_addr_t;

  typedef enum logic [2:0] {
    LC_IDLE,
    LC_SCAN,
    LC_SCAN_LAST,
    LC_SHIFT_RD,
    LC_SHIFT_WR,
    LC_ZERO_TOP,
    LC_DONE
  } lc_state_t;

  localparam logic [15:0] SCORE_0 = 16'd0;
  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

  // Counts above 4 cannot occur in legal play; they score as a four-line clear.
  function automatic logic [15:0] score_for(input logic [2:0] lines);
    case (lines)
      3'd0:    score_for = SCORE_0;
      3'd1:    score_for = SCORE_1;
      3'd2:    score_for = SCORE_2;
      3'd3:    score_for = SCORE_3;
      default: score_for = SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/line_clear_addr_gen.sv
// Combinational board address generator: addr = y*COLS + x (also used by the lock writer).
module line_clear_addr_gen #(
  parameter int COLS   = 10,
  parameter int ADDR_W = 8,
  parameter int Y_W    = 5,
  parameter int X_W    = 4
) (
  input  logic [Y_W-1:0]    y,
  input  logic [X_W-1:0]    x,
  output logic [ADDR_W-1:0] addr
);

  assign addr = ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);

endmodule

// File: rtl/line_clear.sv
// Board line-clear engine: scans rows bottom-up, shifts full rows out, zero-fills row 0.
// Optional LINE_CLEAR_SCORE_EN adds a saturating score accumulator output.
module line_clear
  import tetris_pkg::*;
#(
  parameter int COLS   = BOARD_COLS,
  parameter int ROWS   = BOARD_ROWS,
  parameter int DATA_W = CELL_W,
  parameter int ADDR_W = BOARD_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_Q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              complete,
  output logic [2:0]        lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]       score
`endif
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  lc_state_t         state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  r_q, r_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              row_full_q, row_full_d;
  logic [2:0]        lc_q, lc_d;
  logic              busy_q, busy_d;
  logic              complete_q, complete_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [ROW_W-1:0]  y_sel;
  logic [COL_W-1:0]  x_sel;
  logic              cell_full;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;
`endif

  assign cell_full = (ram_Q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LC_IDLE;
      row_q      <= '0;
      r_q        <= '0;
      col_q      <= '0;
      row_full_q <= 1'b0;
      lc_q       <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      addr_q     <= '0;
      wren_q     <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
      score_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      r_q        <= r_d;
      col_q      <= col_d;
      row_full_q <= row_full_d;
      lc_q       <= lc_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
`ifdef LINE_CLEAR_SCORE_EN
      score_q    <= score_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    r_d        = r_q;
    col_d      = col_q;
    row_full_d = row_full_q;
    lc_d       = lc_q;
    busy_d     = busy_q;
    complete_d = 1'b0;
    case (state_q)
      LC_IDLE: begin
        if (start) begin
          row_d   = LAST_ROW;
          col_d   = '0;
          lc_d    = '0;
          busy_d  = 1'b1;
          state_d = LC_SCAN;
        end
      end
      LC_SCAN: begin
        // ram_Q lags the address by one cycle, so column 0 only seeds the AND.
        row_full_d = (col_q == '0) ? 1'b1 : (row_full_q & cell_full);
        if (col_q == LAST_COL) state_d = LC_SCAN_LAST;
        else                   col_d   = col_q + COL_W'(1);
      end
      LC_SCAN_LAST: begin
        col_d = '0;
        if (row_full_q && cell_full) begin
          if (lc_q != 3'd7) lc_d = lc_q + 3'd1;
          r_d     = row_q;
          state_d = (row_q == '0) ? LC_ZERO_TOP : LC_SHIFT_RD;
        end else if (row_q == '0) begin
          state_d = LC_DONE;
        end else begin
          row_d   = row_q - ROW_W'(1);
          state_d = LC_SCAN;
        end
      end
      LC_SHIFT_RD: state_d = LC_SHIFT_WR;
      LC_SHIFT_WR: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          r_d     = r_q - ROW_W'(1);
          state_d = (r_q == ROW_W'(1)) ? LC_ZERO_TOP : LC_SHIFT_RD;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = LC_SHIFT_RD;
        end
      end
      LC_ZERO_TOP: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = LC_SCAN;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      LC_DONE: begin
        busy_d     = 1'b0;
        complete_d = 1'b1;
        state_d    = LC_IDLE;
      end
      default: state_d = LC_IDLE;
    endcase
  end

`ifdef LINE_CLEAR_SCORE_EN
  always_comb begin
    score_sum = {1'b0, score_q} + {1'b0, score_for(lc_q)};
    score_d   = score_q;
    if (state_q == LC_DONE) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
  assign score = score_q;
`endif

  // Address and write enable are registered for the state being entered, so they
  // line up with that state; only the shift write data passes straight from ram_Q.
  always_comb begin
    y_sel  = '0;
    x_sel  = col_d;
    wren_d = 1'b0;
    case (state_d)
      LC_SCAN:     y_sel = row_d;
      LC_SHIFT_RD: y_sel = r_d - ROW_W'(1);
      LC_SHIFT_WR: begin
        y_sel  = r_d;
        wren_d = 1'b1;
      end
      LC_ZERO_TOP: wren_d = 1'b1;
      default:     x_sel = '0;
    endcase
  end

  line_clear_addr_gen #(
    .COLS  (COLS),
    .ADDR_W(ADDR_W),
    .Y_W   (ROW_W),
    .X_W   (COL_W)
  ) u_addr_gen (
    .y   (y_sel),
    .x   (x_sel),
    .addr(addr_d)
  );

  assign ram_addr      = addr_q;
  assign ram_wren      = wren_q;
  assign ram_data      = (state_q == LC_SHIFT_WR) ? ram_Q : '0;
  assign busy          = busy_q;
  assign complete      = complete_q;
  assign lines_cleared = lc_q;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear with a behavioural 1-cycle-latency board RAM.
module tb_line_clear;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       complete;
  logic [2:0] lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score;
`endif

  always #5 clk = ~clk;

  line_clear dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ram_Q        (ram_q),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .busy         (busy),
    .complete     (complete),
    .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score        (score)
`endif
  );

  logic [5:0] mem      [0:255];
  logic [5:0] init_mem [0:239];
  logic [5:0] exp_mem  [0:239];
  logic       load_req = 1'b0;
  int         wr_cnt = 0;
  int         wr_hi  = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < 240) ? init_mem[i] : 6'd0;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_wren) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_addr >= 8'd10) wr_hi <= wr_hi + 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    int         setup;
    logic [2:0] exp_lines;
    int         exp_writes;
    int         exp_hi;
    int         exp_score;
    int         repulse_at;
  } vec_t;

  // Builds the initial board and the hand-derived final board for each setup.
  task automatic setup_board(input int setup);
    for (int i = 0; i < 240; i++) begin
      init_mem[i] = 6'd0;
      exp_mem[i]  = 6'd0;
    end
    case (setup)
      2: begin
        for (int x = 0; x < 10; x++) init_mem[230+x] = 6'(x + 1);
        init_mem[220] = 6'd5;
        exp_mem[230]  = 6'd5;
      end
      3: for (int i = 200; i < 240; i++) init_mem[i] = 6'd7;
      4: begin
        for (int x = 0; x < 10; x++) begin
          init_mem[230+x] = 6'd2;
          init_mem[210+x] = 6'd2;
        end
        for (int x = 0; x < 9; x++) begin
          init_mem[220+x] = 6'd1;
          exp_mem[230+x]  = 6'd1;
        end
      end
      5: for (int x = 0; x < 10; x++) init_mem[x] = 6'd3;
      6: begin
        for (int x = 0; x < 9; x++) init_mem[100+x] = 6'd3;
        for (int x = 1; x < 10; x++) init_mem[230+x] = 6'd4;
        for (int i = 0; i < 240; i++) exp_mem[i] = init_mem[i];
      end
      default: ;
    endcase
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_pass(input int repulse_at, output int cycles,
                          output bit timed_out, output logic busy1);
    start     = 1'b1;
    cycles    = 0;
    timed_out = 1'b0;
    busy1     = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) busy1 = busy;
      start = (repulse_at != 0 && cycles == repulse_at);
      if (cycles > 10000) timed_out = 1'b1;
    end while (!complete && !timed_out);
    start = 1'b0;
  endtask

  task automatic check_board(input string nm);
    int bad = 0;
    for (int i = 0; i < 240; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(nm, bad, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int         cycles;
    bit         tmo;
    logic       busy1;
    int         w0, h0, wr_seen;

    vecs[0] = '{1, 3'd0,   0,   0,    0,  0};
    vecs[1] = '{2, 3'd1, 240, 230,   40, 40};
    vecs[2] = '{3, 3'd4, 960, 920, 1200,  0};
    vecs[3] = '{4, 3'd2, 470, 450,  100,  0};
    vecs[4] = '{5, 3'd1,  10,   0,   40,  0};
    vecs[5] = '{6, 3'd0,   0,   0,    0,  0};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_complete", complete, 0);
    check("rst_lines", lines_cleared, 0);
`ifdef LINE_CLEAR_SCORE_EN
    check("rst_score", score, 0);
`endif

    // start coincident with reset must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("start_during_reset_busy", busy, 0);
    @(negedge clk);
    check("start_during_reset_busy2", busy, 0);

    foreach (vecs[i]) begin
      do_reset();
      setup_board(vecs[i].setup);
      w0 = wr_cnt;
      h0 = wr_hi;
      run_pass(vecs[i].repulse_at, cycles, tmo, busy1);
      check($sformatf("v%0d_timeout", i), tmo, 0);
      check($sformatf("v%0d_busy_after_start", i), busy1, 1);
      check($sformatf("v%0d_busy_at_complete", i), busy, 0);
      check($sformatf("v%0d_lines", i), lines_cleared, vecs[i].exp_lines);
      if (vecs[i].setup == 1) check("empty_cycles", cycles, 266);
`ifdef LINE_CLEAR_SCORE_EN
      check($sformatf("v%0d_score", i), score, vecs[i].exp_score);
`endif
      @(negedge clk);
      check($sformatf("v%0d_complete_pulse", i), complete, 0);
      @(negedge clk);
      check($sformatf("v%0d_lines_held", i), lines_cleared, vecs[i].exp_lines);
      check($sformatf("v%0d_writes", i), wr_cnt - w0, vecs[i].exp_writes);
      check($sformatf("v%0d_writes_hi", i), wr_hi - h0, vecs[i].exp_hi);
      check_board($sformatf("v%0d_board", i));
    end

    // reset during the third shift write cycle
    do_reset();
    setup_board(2);
    start   = 1'b1;
    wr_seen = 0;
    tmo     = 1'b0;
    cycles  = 0;
    while (wr_seen < 3 && !tmo) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (ram_wren) wr_seen++;
      if (cycles > 2000) tmo = 1'b1;
    end
    check("midreset_reach_wr3", tmo, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_wren", ram_wren, 0);
    check("midreset_busy", busy, 0);
    check("midreset_addr", ram_addr, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_stays_idle", busy, 0);
    setup_board(2);
    run_pass(0, cycles, tmo, busy1);
    check("after_reset_timeout", tmo, 0);
    check("after_reset_lines", lines_cleared, 1);
    repeat (2) @(negedge clk);
    check_board("after_reset_board");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
